char_ram_cmd_ctrl: RTL and testbench

Command sequencer that owns the character RAM write port (40x32 cells, 11-bit address, 8-bit data). It accepts command bytes from a host byte source (UART or SPI front end) over a valid/ready handshake. It tracks the cursor, issues single-cycle RAM writes, runs whole-screen clear, and implements hardware scroll. Scroll works as a ring-buffer row offset exported to the display read-address generator, which computes phys_row = (row + out_row_offset) mod ROWS.

---
 rtl/el_display_pkg.sv | 19 +
 rtl/char_addr_calc.sv | 15 +
 rtl/char_ram_cmd_ctrl.sv | 149 ++++++++++++++
 tb/tb_char_ram_cmd_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/el_display_pkg.sv
// el_display_pkg: shared geometry, command codes and state encoding for the character display.
package el_display_pkg;
  localparam int COLS = 40;
  localparam int ROWS = 32;
  localparam int ADDR_W = 11;
  localparam int COL_W = 6;
  localparam int ROW_W = 5;
  localparam logic [7:0] FILL_CHAR = 8'h00;
  localparam logic [7:0] CMD_LF = 8'h0A;
  localparam logic [7:0] CMD_CR = 8'h0D;
  localparam logic [7:0] CMD_CLEAR = 8'hFF;
  localparam logic [1:0] COL_SET = 2'b10;
  localparam logic [1:0] ROW_SET = 2'b11;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  typedef enum logic [1:0] {IDLE, EXEC, FILL, CLEAR} state_e;
  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
    return (r == ROW_W'(ROWS - 1)) ? '0 : r + 1'b1;
  endfunction
endpackage

// File: rtl/char_addr_calc.sv
// char_addr_calc: maps a logical (col, row) through the ring-buffer row offset to a RAM address.
module char_addr_calc
  import el_display_pkg::*;
(
  input  logic [COL_W-1:0]  col_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic [ROW_W-1:0]  off_i,
  output logic [ADDR_W-1:0] addr_o
);
  logic [ROW_W:0] sum;
  logic [ROW_W:0] phys;
  assign sum = {1'b0, row_i} + {1'b0, off_i};
  assign phys = (sum >= (ROW_W + 1)'(ROWS)) ? sum - (ROW_W + 1)'(ROWS) : sum;
  assign addr_o = ADDR_W'(col_i) + ADDR_W'(phys) * ADDR_W'(COLS);
endmodule

// File: rtl/char_ram_cmd_ctrl.sv
// char_ram_cmd_ctrl: decodes host command bytes into character RAM writes, clear and hardware scroll.
module char_ram_cmd_ctrl
  import el_display_pkg::*;
(
  input  logic              in_main_clock,
  input  logic              in_reset_n,
  input  logic              in_cmd_valid,
  input  logic [7:0]        in_cmd_data,
  output logic              out_cmd_ready,
  output logic [ADDR_W-1:0] out_ram_addr,
  output logic [7:0]        out_ram_data,
  output logic              out_ram_we,
  output logic [ROW_W-1:0]  out_row_offset,
  output logic              out_busy
);
  state_e state_q, state_d;
  logic init_q;
  logic [COL_W-1:0] col_q, col_d, cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d, off_q, off_d, fill_row_q, fill_row_d;
  logic pend_q, pend_d, we_q, we_d, adv, xfer;
  logic [ADDR_W-1:0] addr_q, addr_d, cur_addr, fill_addr;
  logic [7:0] data_q, data_d;

  char_addr_calc u_cur (.col_i(col_q), .row_i(row_q), .off_i(off_q), .addr_o(cur_addr));
  char_addr_calc u_fill (.col_i(cnt_q), .row_i(fill_row_q), .off_i('0), .addr_o(fill_addr));

  assign xfer = in_cmd_valid & out_cmd_ready;

  always_ff @(posedge in_main_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= IDLE;
      init_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
      off_q <= '0;
      fill_row_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      init_q <= 1'b1;
      col_q <= col_d;
      row_q <= row_d;
      off_q <= off_d;
      fill_row_q <= fill_row_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (xfer) state_d = (in_cmd_data == CMD_CLEAR) ? CLEAR : EXEC;
      EXEC:  state_d = pend_q ? FILL : IDLE;
      FILL:  if (cnt_q == COL_W'(COLS)) state_d = IDLE;
      CLEAR: if (addr_q == LAST_ADDR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    off_d = off_q;
    fill_row_d = fill_row_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    we_d = we_q;
    addr_d = addr_q;
    data_d = data_q;
    adv = 1'b0;
    unique case (state_q)
      IDLE: if (xfer) begin
        if (in_cmd_data == CMD_CLEAR) begin
          col_d = '0;
          row_d = '0;
          off_d = '0;
          addr_d = '0;
          data_d = FILL_CHAR;
          we_d = 1'b1;
        end else if (in_cmd_data == CMD_LF) begin
          col_d = '0;
          adv = 1'b1;
        end else if (in_cmd_data == CMD_CR) begin
          col_d = '0;
        end else if (in_cmd_data[7:6] == COL_SET) begin
          col_d = (in_cmd_data[5:0] >= COL_W'(COLS)) ? '0 : in_cmd_data[COL_W-1:0];
        end else if (in_cmd_data[7:6] == ROW_SET) begin
          row_d = (in_cmd_data[5:0] >= 6'(ROWS)) ? '0 : in_cmd_data[ROW_W-1:0];
        end else begin
          we_d = 1'b1;
          addr_d = cur_addr;
          data_d = in_cmd_data;
          adv = (col_q == COL_W'(COLS - 1));
          col_d = adv ? '0 : col_q + 1'b1;
        end
      end
      EXEC: begin
        we_d = 1'b0;
        if (pend_q) begin
          off_d = row_inc(off_q);
          fill_row_d = off_q;
          cnt_d = '0;
        end
      end
      FILL: begin
        if (cnt_q == COL_W'(COLS)) begin
          we_d = 1'b0;
          pend_d = 1'b0;
        end else begin
          we_d = 1'b1;
          addr_d = fill_addr;
          data_d = FILL_CHAR;
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          we_d = 1'b0;
          addr_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: we_d = 1'b0;
    endcase
    // Bottom row reached: the cursor stays put and the screen scrolls instead.
    if (adv) begin
      if (row_q == ROW_W'(ROWS - 1)) pend_d = 1'b1;
      else row_d = row_q + 1'b1;
    end
  end

  always_comb begin
    out_cmd_ready = init_q && (state_q == IDLE);
    out_busy = ~out_cmd_ready;
    out_ram_addr = addr_q;
    out_ram_data = data_q;
    out_ram_we = we_q;
    out_row_offset = off_q;
  end
endmodule

// File: tb/tb_char_ram_cmd_ctrl.sv
// tb_char_ram_cmd_ctrl: randomized and directed checks of the command sequencer against a cursor/screen model.
module tb_char_ram_cmd_ctrl;
  localparam int COLS = 40;
  localparam int ROWS = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic ready, we, busy;
  logic [10:0] addr;
  logic [7:0] wdata;
  logic [4:0] offset;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int xfer_cyc = 0;
  int m_col = 0, m_row = 0, m_off = 0;
  logic [18:0] exp_q[$];
  logic [18:0] act_q[$];

  char_ram_cmd_ctrl dut (
    .in_main_clock(clk), .in_reset_n(rst_n), .in_cmd_valid(valid), .in_cmd_data(data),
    .out_cmd_ready(ready), .out_ram_addr(addr), .out_ram_data(wdata), .out_ram_we(we),
    .out_row_offset(offset), .out_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (rst_n && we) act_q.push_back({addr, wdata});

  task automatic model_adv();
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int i = 0; i < COLS; i++) exp_q.push_back({11'(m_off * COLS + i), 8'h00});
      m_off = (m_off + 1) % ROWS;
    end
  endtask

  task automatic model(input logic [7:0] b);
    if (b == 8'hFF) begin
      for (int i = 0; i < COLS * ROWS; i++) exp_q.push_back({11'(i), 8'h00});
      m_col = 0; m_row = 0; m_off = 0;
    end else if (b == 8'h0A) begin
      m_col = 0; model_adv();
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b >= 8'h80 && b <= 8'hBF) begin
      m_col = (int'(b) - 128 >= COLS) ? 0 : int'(b) - 128;
    end else if (b >= 8'hC0) begin
      m_row = (int'(b) - 192 >= ROWS) ? 0 : int'(b) - 192;
    end else begin
      exp_q.push_back({11'(m_col + COLS * ((m_row + m_off) % ROWS)), b});
      m_col++;
      if (m_col == COLS) begin m_col = 0; model_adv(); end
    end
  endtask

  task automatic abort(input string what);
    n_fail++;
    $display("FAIL %s: timed out waiting for ready, got ready=%0b required 1", what, ready);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    valid = 1'b1; data = b;
    while (!ready) begin
      @(negedge clk);
      if (++n > 3000) abort("send");
    end
    @(posedge clk);
    xfer_cyc = cyc;
    #1 valid = 1'b0;
    model(b);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!ready) begin
      @(negedge clk);
      if (++n > 3000) abort("wait_idle");
    end
  endtask

  task automatic check_writes(input string name);
    n_chk++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d writes, required %0d", name, act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_write[%0d]: got addr=%0d data=%h, required addr=%0d data=%h",
                 name, i, act_q[i][18:8], act_q[i][7:0], exp_q[i][18:8], exp_q[i][7:0]);
      end
    end
    n_chk++;
    if (offset !== 5'(m_off)) begin
      n_fail++;
      $display("FAIL %s_offset: got %0d, required %0d", name, offset, m_off);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({ready, we, addr, wdata, offset, busy} !== {1'b0, 1'b0, 11'd0, 8'd0, 5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%0b we=%0b addr=%0d data=%h off=%0d busy=%0b, required 0 0 0 00 0 1",
               ready, we, addr, wdata, offset, busy);
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_chk++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL release_ready: got %0b, required 0", ready); end
    @(posedge clk) #1;
    n_chk++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL first_edge_ready: got ready=%0b busy=%0b, required 1 0", ready, busy);
    end
  endtask

  task automatic test_single_write();
    send(8'h41);
    @(negedge clk);
    n_chk++;
    if ({we, addr, wdata, ready} !== {1'b1, 11'd0, 8'h41, 1'b0}) begin
      n_fail++;
      $display("FAIL write_A: got we=%0b addr=%0d data=%h ready=%0b, required 1 0 41 0", we, addr, wdata, ready);
    end
    @(negedge clk);
    n_chk++;
    if ({we, ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL latency_A: got we=%0b ready=%0b, required 0 1", we, ready);
    end
    check_writes("single");
  endtask

  task automatic test_set_write();
    send(8'h85); send(8'hC3); send(8'h5A);
    wait_idle();
    n_chk++;
    if (exp_q.size() != 1 || act_q.size() < 1 || act_q[0] !== {11'd125, 8'h5A}) begin
      n_fail++;
      $display("FAIL set_write_125: got %0d writes first=%h, required 1 write addr 125 data 5a",
               act_q.size(), act_q.size() > 0 ? act_q[0] : 19'h0);
    end
    check_writes("set_write");
  endtask

  task automatic test_scroll();
    send(8'hDF); send(8'hA7); send(8'h78);
    wait_idle();
    n_chk++;
    if (offset !== 5'd1) begin n_fail++; $display("FAIL scroll_offset: got %0d, required 1", offset); end
    check_writes("scroll");
    send(8'h79);
    wait_idle();
    check_writes("after_scroll");
  endtask

  task automatic test_back_to_back();
    int t0;
    send(8'h61);
    t0 = xfer_cyc;
    send(8'h62);
    n_chk++;
    if (xfer_cyc - t0 != 2) begin
      n_fail++;
      $display("FAIL back_to_back: got spacing %0d cycles, required 2", xfer_cyc - t0);
    end
    wait_idle();
    check_writes("b2b");
  endtask

  task automatic test_clear();
    int nwe = 0, ncyc = 0;
    send(8'hFF);
    @(negedge clk);
    while (!ready) begin
      if (we) nwe++;
      ncyc++;
      if (ncyc > 3000) abort("clear");
      @(negedge clk);
    end
    n_chk++;
    if (nwe != 1280 || ncyc != 1280) begin
      n_fail++;
      $display("FAIL clear_length: got %0d we cycles over %0d busy cycles, required 1280 and 1280", nwe, ncyc);
    end
    check_writes("clear");
  endtask

  task automatic test_out_of_range();
    send(8'h85); send(8'hC5); send(8'hBF); send(8'hE5); send(8'h21);
    wait_idle();
    n_chk++;
    if (act_q.size() < 1 || act_q[0][18:8] !== 11'd0) begin
      n_fail++;
      $display("FAIL oob_addr: got %0d writes first addr=%0d, required addr 0",
               act_q.size(), act_q.size() > 0 ? act_q[0][18:8] : 11'd0);
    end
    check_writes("oob");
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      b = r < 60 ? 8'($urandom_range(32, 126)) : r < 70 ? 8'h0A : r < 74 ? 8'h0D :
          r < 86 ? 8'($urandom_range(128, 191)) : 8'($urandom_range(192, 254));
      send(b);
      if (k % 25 == 24) begin wait_idle(); check_writes("random"); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int nwe = 0;
    send(8'h85);
    send(8'hFF);
    @(negedge clk);
    valid = 1'b1; data = 8'h51;
    repeat (400) @(negedge clk);
    n_chk++;
    if (we !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear: got we=%0b ready=%0b, required 1 0", we, ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({we, addr, wdata, offset, ready} !== {1'b0, 11'd0, 8'd0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got we=%0b addr=%0d data=%h off=%0d ready=%0b, required 0 0 00 0 0",
               we, addr, wdata, offset, ready);
    end
    act_q.delete(); exp_q.delete();
    m_col = 0; m_row = 0; m_off = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; valid = 1'b0;
    repeat (20) @(negedge clk) if (we) nwe++;
    n_chk++;
    if (nwe != 0) begin n_fail++; $display("FAIL post_reset_idle: got %0d writes, required 0", nwe); end
    act_q.delete();
    send(8'h51);
    wait_idle();
    check_writes("post_reset");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_set_write();
    test_scroll();
    test_back_to_back();
    test_clear();
    test_out_of_range();
    test_random();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
